// File: rtl/aud_pkg.sv
// Shared state type and default widths for the SRAM audio player and its serializer.
package aud_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 20;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_PLAY       = 2'd2,
      ST_PAUSE      = 2'd3
   } player_state_t;

endpackage

// File: rtl/aud_i2s_serializer.sv
// MSB-first shifter for one I2S channel slot; emits DATA_W bits after each start, then zeros.
module aud_i2s_serializer
   import aud_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_chan_start,
   input  logic [DATA_W-1:0] i_sample,
   output logic              o_bit
);

   logic [DATA_W-1:0] shreg_q;
   logic [CNT_W-1:0]  cnt_q;

   // clear beats start so a pause or stop on a channel edge stays silent
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (i_clear) begin
         shreg_q <= '0;
         cnt_q   <= '0;
      end else if (i_load || i_chan_start) begin
         shreg_q <= i_sample;
         cnt_q   <= CNT_W'(DATA_W);
      end else if (cnt_q != '0) begin
         shreg_q <= {shreg_q[DATA_W-2:0], 1'b0};
         cnt_q   <= cnt_q - CNT_W'(1);
      end
   end

   assign o_bit = (cnt_q != '0) & shreg_q[DATA_W-1];

endmodule

// File: rtl/aud_sram_player.sv
// Plays mono samples from asynchronous SRAM out to an I2S DAC, one sample per LR frame.
// Define AUD_PLAYER_LOOP_EN to wrap back to address 0 at end-of-data instead of stopping.
module aud_sram_player
   import aud_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lrc,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_dac_data,
   output logic              o_busy,
   output logic              o_done,
   output player_state_t     o_state
);

   player_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] sample_q, sample_d, ser_sample;
   logic              last_q, last_d;
   logic              done_q, done_d;
   logic              lrc_q;
   logic              frame_start, chan_start, at_end;
   logic              load, ser_clear, ser_start, ser_bit;

   assign frame_start = lrc_q & ~i_lrc;
   assign chan_start  = lrc_q ^ i_lrc;
   assign at_end      = (addr_q == i_end_addr);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sample_d  = sample_q;
      last_d    = last_q;
      done_d    = 1'b0;
      load      = 1'b0;
      ser_clear = 1'b0;
      if (i_stop && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         addr_d    = '0;
         last_d    = 1'b0;
         ser_clear = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_d = ST_WAIT_FRAME;
                  addr_d  = '0;
                  last_d  = 1'b0;
               end
            end
            ST_WAIT_FRAME: begin
               if (frame_start) load = 1'b1;
            end
            ST_PLAY: begin
               if (frame_start && last_q) begin
                  done_d = 1'b1;
`ifdef AUD_PLAYER_LOOP_EN
                  load   = 1'b1;
`else
                  state_d   = ST_IDLE;
                  addr_d    = '0;
                  last_d    = 1'b0;
                  ser_clear = 1'b1;
`endif
               end else if (i_pause) begin
                  state_d   = ST_PAUSE;
                  ser_clear = 1'b1;
               end else if (frame_start) begin
                  load = 1'b1;
               end
            end
            ST_PAUSE: begin
               if (!i_pause) state_d = ST_WAIT_FRAME;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // SRAM data has been stable for the whole previous cycle at a frame start
      if (load) begin
         state_d  = ST_PLAY;
         sample_d = i_sram_data;
         last_d   = at_end;
         addr_d   = addr_q + ADDR_W'(1);
`ifdef AUD_PLAYER_LOOP_EN
         if (at_end) addr_d = '0;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         sample_q <= '0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         lrc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         sample_q <= sample_d;
         last_q   <= last_d;
         done_q   <= done_d;
         lrc_q    <= i_lrc;
      end
   end

   assign ser_start  = chan_start & (state_q == ST_PLAY);
   assign ser_sample = load ? i_sram_data : sample_q;

   aud_i2s_serializer #(.DATA_W(DATA_W)) u_ser (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_clear      (ser_clear),
      .i_load       (load),
      .i_chan_start (ser_start),
      .i_sample     (ser_sample),
      .o_bit        (ser_bit)
   );

   assign o_sram_addr = addr_q;
   assign o_dac_data  = ser_bit & (state_q == ST_PLAY);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = done_q;
   assign o_state     = state_q;

endmodule

// File: tb/tb_aud_sram_player.sv
// Bench for aud_sram_player: frame-level playback model, table scenarios, hand corner cases, random runs.
module tb_aud_sram_player;
   import aud_pkg::*;

   localparam int EV_NONE = 0, EV_PAUSE_ON = 1, EV_PAUSE_OFF = 2, EV_RESET = 3, EV_START = 4, EV_STOP = 5;
`ifdef AUD_PLAYER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic          i_clk, i_rst_n, i_lrc, i_start, i_pause, i_stop;
   logic [19:0]   i_end_addr;
   logic [15:0]   i_sram_data;
   logic [19:0]   o_sram_addr;
   logic          o_dac_data, o_busy, o_done;
   player_state_t o_state;

   logic [15:0] mem [0:15];
   int checks = 0;
   int failures = 0;
   int done_cnt = 0;

   typedef struct {
      int end_addr;
      int len_l;
      int len_r;
      int pause_addr;
      int hold;
      int exp_last_addr;
   } vec_t;
   vec_t tbl [4];

   aud_sram_player dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_lrc       (i_lrc),
      .i_start     (i_start),
      .i_pause     (i_pause),
      .i_stop      (i_stop),
      .i_end_addr  (i_end_addr),
      .i_sram_data (i_sram_data),
      .o_sram_addr (o_sram_addr),
      .o_dac_data  (o_dac_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_state     (o_state)
   );

   // asynchronous SRAM model
   assign i_sram_data = mem[o_sram_addr[3:0]];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) if (o_done === 1'b1) done_cnt++;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " dac"}, o_dac_data, 0);
      check({tag, " busy"}, o_busy, 0);
      check({tag, " done"}, o_done, 0);
      check({tag, " addr"}, o_sram_addr, 0);
      check({tag, " state"}, o_state, ST_IDLE);
   endtask

   // one channel slot: drive the LR level, collect 16 bits, verify the tail is silent
   task automatic chan(input logic lrc_val, input int len, input int ev_cyc, input int ev_kind,
                       output logic [15:0] word, output logic tail_ok);
      word    = '0;
      tail_ok = 1'b1;
      i_lrc   = lrc_val;
      for (int i = 0; i < len; i++) begin
         tick();
         if (i < 16) word[15-i] = o_dac_data;
         else if (o_dac_data !== 1'b0) tail_ok = 1'b0;
         if (i == ev_cyc + 1) begin
            if (ev_kind == EV_RESET) i_rst_n = 1'b1;
            if (ev_kind == EV_START) i_start = 1'b0;
            if (ev_kind == EV_STOP)  i_stop  = 1'b0;
         end
         if (i == ev_cyc) begin
            case (ev_kind)
               EV_PAUSE_ON:  i_pause = 1'b1;
               EV_PAUSE_OFF: i_pause = 1'b0;
               EV_START:     i_start = 1'b1;
               EV_STOP:      i_stop  = 1'b1;
               EV_RESET: begin
                  i_rst_n = 1'b0;
                  #1;
                  check_idle_outputs("async reset");
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic frame(input int ll, input int lr, input int evl_cyc, input int evl_kind,
                        input int evr_cyc, input int evr_kind,
                        input logic [15:0] exp_l, input logic [15:0] exp_r, input string tag);
      logic [15:0] w;
      logic        ok;
      chan(1'b0, ll, evl_cyc, evl_kind, w, ok);
      check({tag, " left word"}, w, exp_l);
      check({tag, " left tail"}, ok, 1);
      chan(1'b1, lr, evr_cyc, evr_kind, w, ok);
      check({tag, " right word"}, w, exp_r);
      check({tag, " right tail"}, ok, 1);
   endtask

   task automatic start_player(input string tag);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check({tag, " start state"}, o_state, ST_WAIT_FRAME);
      check({tag, " start busy"}, o_busy, 1);
      check({tag, " start addr"}, o_sram_addr, 0);
   endtask

   task automatic stop_player(input string tag);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      check({tag, " stop state"}, o_state, ST_IDLE);
      check({tag, " stop addr"}, o_sram_addr, 0);
      check({tag, " stop busy"}, o_busy, 0);
   endtask

   // Reference: addresses 0..e play in order on both channels; a pause discards the
   // sample in flight and resumes at the following address; the frame after e ends playback.
   task automatic run_playback(input int e, input int ll, input int lr, input int pause_addr,
                               input int hold, input int exp_last_addr, input string tag);
      int          a, d0, pc;
      logic [15:0] m;
      bit          fin;
      i_end_addr = 20'(e);
      d0  = done_cnt;
      start_player(tag);
      a   = 0;
      fin = 1'b0;
      while (!fin) begin
         if (a == pause_addr) begin
            pc = $urandom_range(2, 12);
            m  = mem[a] & ~(16'hFFFF >> (pc + 1));
            if (hold == 0) begin
               frame(ll, lr, pc, EV_PAUSE_ON, 5, EV_PAUSE_OFF, m, 16'h0, {tag, " paused"});
            end else begin
               frame(ll, lr, pc, EV_PAUSE_ON, -1, EV_NONE, m, 16'h0, {tag, " paused"});
               check({tag, " pause state"}, o_state, ST_PAUSE);
               for (int h = 1; h <= hold; h++)
                  frame(ll, lr, -1, EV_NONE, (h == hold) ? 5 : -1, (h == hold) ? EV_PAUSE_OFF : EV_NONE,
                        16'h0, 16'h0, {tag, " held"});
            end
            check({tag, " held addr"}, o_sram_addr, a + 1);
            a++;
         end
         frame(ll, lr, -1, EV_NONE, (a == 0) ? 3 : -1, (a == 0) ? EV_START : EV_NONE,
               mem[a], mem[a], {tag, " play"});
         if (a == e) begin
            check({tag, " last addr"}, o_sram_addr, exp_last_addr);
            fin = 1'b1;
         end else begin
            check({tag, " addr"}, o_sram_addr, a + 1);
            a++;
         end
      end
      check({tag, " no early done"}, done_cnt - d0, 0);
`ifdef AUD_PLAYER_LOOP_EN
      frame(ll, lr, -1, EV_NONE, -1, EV_NONE, mem[0], mem[0], {tag, " wrap"});
      check({tag, " wrap done"}, done_cnt - d0, 1);
      check({tag, " wrap busy"}, o_busy, 1);
      check({tag, " wrap addr"}, o_sram_addr, (e == 0) ? 0 : 1);
      stop_player(tag);
`else
      frame(ll, lr, -1, EV_NONE, -1, EV_NONE, 16'h0, 16'h0, {tag, " end"});
      check({tag, " end done"}, done_cnt - d0, 1);
      check({tag, " end state"}, o_state, ST_IDLE);
      check({tag, " end addr"}, o_sram_addr, 0);
      check({tag, " end busy"}, o_busy, 0);
`endif
   endtask

   task automatic load_fixed_mem();
      for (int i = 0; i < 16; i++) mem[i] = 16'h0;
      mem[0] = 16'hA5C3;
      mem[1] = 16'h1234;
      mem[2] = 16'hFEDC;
      mem[3] = 16'h8001;
   endtask

   initial begin
      int          d0;
      logic [15:0] w;
      logic        ok;
      i_rst_n = 1'b0;
      i_lrc = 1'b1;
      i_start = 1'b0;
      i_pause = 1'b0;
      i_stop = 1'b0;
      i_end_addr = '0;
      load_fixed_mem();
      #2;
      check_idle_outputs("reset");
      tick();
      i_rst_n = 1'b1;
      repeat (3) tick();

      tbl[0] = '{end_addr: 0, len_l: 20, len_r: 20, pause_addr: -1, hold: 0, exp_last_addr: LOOP ? 0 : 1};
      tbl[1] = '{end_addr: 3, len_l: 18, len_r: 22, pause_addr: -1, hold: 0, exp_last_addr: LOOP ? 0 : 4};
      tbl[2] = '{end_addr: 3, len_l: 20, len_r: 20, pause_addr: 1,  hold: 3, exp_last_addr: LOOP ? 0 : 4};
      tbl[3] = '{end_addr: 1, len_l: 17, len_r: 17, pause_addr: -1, hold: 0, exp_last_addr: LOOP ? 0 : 2};
      for (int t = 0; t < 4; t++)
         run_playback(tbl[t].end_addr, tbl[t].len_l, tbl[t].len_r, tbl[t].pause_addr,
                      tbl[t].hold, tbl[t].exp_last_addr, $sformatf("tbl%0d", t));

      // stop mid-channel, then stop while idle
      i_end_addr = 20'd3;
      d0 = done_cnt;
      start_player("stop");
      frame(20, 20, -1, EV_NONE, -1, EV_NONE, mem[0], mem[0], "stop f1");
      frame(20, 20, 6, EV_STOP, -1, EV_NONE, mem[1] & ~(16'hFFFF >> 7), 16'h0, "stop f2");
      check("stop state", o_state, ST_IDLE);
      check("stop addr", o_sram_addr, 0);
      check("stop done", done_cnt - d0, 0);
      stop_player("idle stop");

      // stop coinciding with the end-of-data frame start
      i_end_addr = 20'd0;
      d0 = done_cnt;
      start_player("stop eod");
      frame(20, 20, -1, EV_NONE, -1, EV_NONE, mem[0], mem[0], "stop eod f1");
      i_stop = 1'b1;
      chan(1'b0, 20, -1, EV_STOP, w, ok);
      check("stop eod state", o_state, ST_IDLE);
      check("stop eod addr", o_sram_addr, 0);
      check("stop eod word", w, 0);
      check("stop eod done", done_cnt - d0, 0);
      chan(1'b1, 20, -1, EV_NONE, w, ok);

      // reset at bit 7 of the right channel, then restart from address 0
      i_end_addr = 20'd3;
      start_player("rst");
      frame(20, 20, -1, EV_NONE, 8, EV_RESET, mem[0], mem[0] & ~(16'hFFFF >> 9), "rst f1");
      check("rst state", o_state, ST_IDLE);
      start_player("rst again");
      frame(20, 20, -1, EV_NONE, -1, EV_NONE, mem[0], mem[0], "rst f2");
      check("rst addr", o_sram_addr, 1);
      stop_player("rst");

      // randomized runs against the reference
      for (int r = 0; r < 12; r++) begin
         int e, pa;
         for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
         e  = $urandom_range(1, 5);
         pa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, e - 1) : -1;
         run_playback(e, $urandom_range(17, 24), $urandom_range(17, 24), pa,
                      $urandom_range(0, 3), LOOP ? 0 : e + 1, $sformatf("rnd%0d", r));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
